pixel_frame_sequencer: RTL and testbench
========================================

Name: pixel_frame_sequencer

Overview:
- Sequences the pixel controller datapath over one full frame.
- Streams NUM_PIXELS bytes from an input frame memory into the datapath, holding threshold/value/select constant for the frame.
- Writes each datapath result to the output frame memory at the matching address, with write backpressure.
- Replaces the per-pixel hand-driven stimulus loop; sits between the frame memories and the pixel controller.

Parameters:
NUM_PIXELS, 98304, pixels per frame (256x384 RGB bytes)
ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= NUM_PIXELS
PIPE_LAT, 1, clock cycles from px_in to px_out at the datapath (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process a frame; ignored unless idle
abort  in  1  synchronous cancel of a frame in flight
cfg_threshold  in  8  threshold for the frame
cfg_value  in  8  value operand for the frame
cfg_select  in  2  operation select for the frame
rd_en  out  1  input-memory read strobe
rd_addr  out  ADDR_W  input-memory read address
rd_data  in  8  input-memory data; valid 1 cycle after rd_en, held while rd_en low
px_en  out  1  datapath clock enable
px_in  out  8  pixel to datapath (= rd_data)
px_threshold  out  8  latched threshold
px_value  out  8  latched value
px_select  out  2  latched select
px_out  in  8  datapath result
wr_en  out  1  output-memory write strobe
wr_addr  out  ADDR_W  output-memory write address
wr_data  out  8  output-memory write data (= px_out)
wr_ready  in  1  output memory accepts the write this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset (rst_n low, async): state IDLE; all counters 0; rd_en, wr_en, px_en, busy and done are 0; rd_addr, wr_addr and px_threshold/value/select are 0.
- States:
  - IDLE: start=1 at an edge latches cfg_* into px_* and clears rd_cnt and wr_cnt. Next state RUN; busy=1 from the next cycle.
  - RUN: continues until wr_cnt reaches NUM_PIXELS, then next state DONE.
  - DONE: lasts one cycle with done=1 and busy=0, then IDLE.
- Read side: rd_en = RUN & (rd_cnt < NUM_PIXELS) & ~stall; rd_addr = rd_cnt; rd_cnt increments on each rd_en.
- Valid tracking: a valid shift register of depth 1+PIPE_LAT tracks issued reads.
  - It shifts only when px_en=1.
  - px_en = busy & ~stall.
- Write side:
  - wr_en = (valid tap at depth 1+PIPE_LAT); wr_addr = wr_cnt; wr_data = px_out.
  - A write completes when wr_en & wr_ready; wr_cnt then increments.
- Stall = wr_en & ~wr_ready. During a stall:
  - rd_en=0 and px_en=0; the pipeline freezes.
  - wr_en, wr_addr and wr_data stay stable until accepted.
- Latency with no stalls, counting the start-accept edge as E0 and cycle k as the interval after edge E(k-1):
  - rd_en high in cycles 1..NUM_PIXELS.
  - wr_en high in cycles 2+PIPE_LAT .. NUM_PIXELS+1+PIPE_LAT.
  - done in cycle NUM_PIXELS+2+PIPE_LAT.
- Counters are ADDR_W+1 bits wide, so NUM_PIXELS = 2^ADDR_W is representable. Addresses never exceed NUM_PIXELS-1; there is no wrap.
- start while busy or in DONE: ignored; the latched cfg is unchanged.
- cfg_* changes mid-frame have no effect on px_*.
- abort in RUN: next state IDLE, with no done pulse.
  - rd_en, wr_en and px_en drop in the cycle after the abort edge.
  - In-flight valids are cleared.
  - abort has priority over a same-edge write completion; that write may still have been accepted.
- abort in IDLE or DONE: no effect; a DONE pulse completes normally.
- start and abort both high in IDLE: start wins.
- rst_n asserted mid-frame: immediate return to reset values; memory contents are not this block's concern.

Test Plan:
- NUM_PIXELS=4, PIPE_LAT=1, wr_ready=1, input {0x10,0xA0,0xFF,0x3C}, start at E0 -> rd_en cycles 1-4 addr 0-3; wr_en cycles 3-6 addr 0-3 with datapath results; done=1 only in cycle 7; busy high cycles 1-6.
- Same frame, wr_ready low cycles 4-5 -> wr_en/wr_addr=1/wr_data held through cycles 4-5; no rd_en or px_en in those cycles; all 4 writes land at correct addresses; done in cycle 9.
- start pulsed again in cycle 3 with cfg_threshold=0x20 -> ignored; px_threshold stays at the frame-1 value; exactly one done.
- abort in cycle 4 of a 4-pixel frame -> wr_en=0 from cycle 5; no done; state IDLE; next start runs a full clean frame from addr 0.
- rst_n low during cycle 3 -> all outputs 0 immediately (async); after release, start produces the nominal timing.
- Full default frame (98304, select=0, threshold=160, value=60) versus golden output file -> byte-exact match; done at cycle 98307.

Source files
------------

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//   Streams one frame of NUM_PIXELS bytes from an input frame memory through
//   the pixel-controller datapath and writes each result to the output frame
//   memory at the matching address. The threshold/value/select operands are
//   latched at frame start and held for the whole frame.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, abort       frame request (honoured only in IDLE) / cancel in RUN
//   cfg_threshold/value/select   operands captured at start
//   rd_en, rd_addr     input-memory read; rd_data returns one cycle later
//   px_en, px_in       datapath enable and pixel (px_in = rd_data)
//   px_threshold/value/select    latched operands to the datapath
//   px_out             datapath result, PIPE_LAT enabled cycles after px_in
//   wr_en, wr_addr, wr_data, wr_ready   output-memory write port
//   busy, done         frame in progress / one-cycle completion pulse
//   dbg_state          current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a write transfers on any rising edge where wr_en && wr_ready.
// While wr_en is high and wr_ready is low, wr_en/wr_addr/wr_data hold and the
// whole read/datapath pipeline freezes (no rd_en, no px_en).
module pixel_frame_sequencer #(
  parameter int NUM_PIXELS = 98304,
  parameter int ADDR_W     = 17,
  parameter int PIPE_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_threshold,
  input  logic [7:0]        cfg_value,
  input  logic [1:0]        cfg_select,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              px_en,
  output logic [7:0]        px_in,
  output logic [7:0]        px_threshold,
  output logic [7:0]        px_value,
  output logic [1:0]        px_select,
  input  logic [7:0]        px_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] NUM_PX  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PX = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  // vld[0] marks read data present at px_in; vld[PIPE_LAT] marks a result at px_out.
  logic [PIPE_LAT:0] vld;
  logic              stall;
  logic              wr_fire;

  assign wr_en     = vld[PIPE_LAT];
  assign stall     = wr_en & ~wr_ready;
  assign wr_fire   = wr_en & wr_ready;
  assign rd_en     = (state == ST_RUN) && (rd_cnt < NUM_PX) && !stall;
  assign px_en     = busy & ~stall;
  assign rd_addr   = rd_cnt[ADDR_W-1:0];
  assign wr_addr   = wr_cnt[ADDR_W-1:0];
  assign wr_data   = px_out;
  assign px_in     = rd_data;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      vld          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      px_threshold <= '0;
      px_value     <= '0;
      px_select    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start outranks a simultaneous abort here: abort only cancels RUN.
          if (start) begin
            px_threshold <= cfg_threshold;
            px_value     <= cfg_value;
            px_select    <= cfg_select;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            vld          <= '0;
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Drops in-flight results; a write accepted on this same edge
            // may already have landed in the output memory.
            vld   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (px_en) vld <= {vld[PIPE_LAT-1:0], rd_en};
            if (wr_fire) begin
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == LAST_PX) begin
                vld   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          vld   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer with a 4-pixel frame (ADDR_W=2, so the frame
// exactly fills the address space) and a one-stage datapath stand-in.
module tb_pixel_frame_sequencer;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0, wr_ready = 1'b1;
  logic [7:0]    cfg_threshold = '0, cfg_value = '0;
  logic [1:0]    cfg_select = '0;
  logic          rd_en, px_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, px_in, px_threshold, px_value, px_out, wr_data;
  logic [1:0]    px_select, dbg_state;

  pixel_frame_sequencer #(.NUM_PIXELS(N), .ADDR_W(AW), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_threshold(cfg_threshold), .cfg_value(cfg_value), .cfg_select(cfg_select),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .px_en(px_en), .px_in(px_in), .px_threshold(px_threshold),
    .px_value(px_value), .px_select(px_select), .px_out(px_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- environment: memories and datapath ----------------
  logic [7:0] mem_in  [N];
  logic [7:0] mem_out [N];
  logic [7:0] rd_data_q, px_out_q;

  function automatic logic [7:0] dp_f(input logic [7:0] px, input logic [7:0] thr,
                                      input logic [7:0] val, input logic [1:0] sel);
    logic [8:0] sum;
    sum = {1'b0, px} + {1'b0, val};
    case (sel)
      2'd0:    return (px > thr) ? val : px;
      2'd1:    return sum[8] ? 8'hFF : sum[7:0];
      2'd2:    return px ^ val;
      default: return ~px;
    endcase
  endfunction

  always @(posedge clk) if (rd_en) rd_data_q <= mem_in[rd_addr];
  always @(posedge clk) if (px_en) px_out_q <= dp_f(px_in, px_threshold, px_value, px_select);
  always @(posedge clk) if (wr_en && wr_ready) mem_out[wr_addr] <= wr_data;
  assign rd_data = rd_data_q;
  assign px_out  = px_out_q;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: queue of expected results, index counters, and
  // the cycle budget a frame must meet (nominal length plus stall cycles).
  logic [7:0]    exp_q[$];
  bit            m_run = 0, m_done = 0, m_hold = 0;
  int            m_ridx = 0, m_widx = 0, m_cyc = 0, m_stalls = 0;
  logic [7:0]    m_thr = '0, m_val = '0;
  logic [1:0]    m_sel = '0;
  logic [AW-1:0] m_hold_addr;
  logic [7:0]    m_hold_data;

  initial forever begin
    bit stall;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outputs", {rd_en, wr_en, px_en, busy, done, rd_addr, wr_addr,
                            px_threshold, px_value, px_select}, 32'd0);
      m_run = 0; m_done = 0; m_hold = 0; exp_q.delete();
      m_thr = '0; m_val = '0; m_sel = '0;
    end else begin
      stall = wr_en && !wr_ready;
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("latched_cfg", {px_threshold, px_value, px_select}, {m_thr, m_val, m_sel});
      if (m_run) begin
        chk("rd_en", rd_en, (m_ridx < N) && !stall);
        if (rd_en) chk("rd_addr", rd_addr, m_ridx);
        chk("px_en", px_en, !stall);
        if (m_hold) chk("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, m_hold_addr, m_hold_data});
        if (wr_en) begin
          chk("wr_addr", wr_addr, m_widx);
          if (exp_q.size() > 0) chk("wr_data", wr_data, exp_q[0]);
          else chk("wr_extra", 1'b1, 1'b0);
        end
      end else begin
        chk("quiet_outputs", {rd_en, wr_en, px_en}, 3'd0);
      end
      if (m_done) chk("done_cycle", m_cyc, N + 2 + LAT + m_stalls);

      // advance the reference across the coming edge
      if (m_done) begin
        m_done = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1; m_thr = cfg_threshold; m_val = cfg_value; m_sel = cfg_select;
          exp_q.delete();
          for (int i = 0; i < N; i++) exp_q.push_back(dp_f(mem_in[i], cfg_threshold, cfg_value, cfg_select));
          m_ridx = 0; m_widx = 0; m_cyc = 1; m_stalls = 0; m_hold = 0;
        end
      end else if (abort) begin
        m_run = 0; m_hold = 0; exp_q.delete();
      end else begin
        if (rd_en) m_ridx++;
        if (stall) begin
          m_stalls++; m_hold = 1; m_hold_addr = wr_addr; m_hold_data = wr_data;
        end else m_hold = 0;
        if (wr_en && wr_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_widx++;
          if (m_widx == N) begin m_run = 0; m_done = 1; end
        end
        m_cyc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic          rec_rd_en [1:12], rec_wr_en [1:12], rec_px_en [1:12];
  logic          rec_done  [1:12], rec_busy  [1:12];
  logic [AW-1:0] rec_rd_addr [1:12], rec_wr_addr [1:12];
  logic [7:0]    rec_wr_data [1:12], rec_thr [1:12];
  logic [7:0]    lit_out [4];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Starts a frame at the next edge (E0) and records cycles 1..ncyc.
  task automatic run_directed(input int ncyc, input int st_lo, input int st_hi,
                              input int abort_at, input int restart_at);
    start = 1'b1;
    tick();
    for (int k = 1; k <= ncyc; k++) begin
      wr_ready = !(k >= st_lo && k <= st_hi);
      abort    = (k == abort_at);
      start    = (k == restart_at);
      if (k == restart_at) cfg_threshold = 8'h20;
      @(negedge clk);
      rec_rd_en[k] = rd_en;   rec_rd_addr[k] = rd_addr; rec_px_en[k] = px_en;
      rec_wr_en[k] = wr_en;   rec_wr_addr[k] = wr_addr; rec_wr_data[k] = wr_data;
      rec_done[k]  = done;    rec_busy[k]    = busy;    rec_thr[k]     = px_threshold;
      tick();
    end
    start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
  endtask

  task automatic check_nominal(input string tag);
    for (int k = 1; k <= 9; k++) begin
      chk({tag, "_rd_en"}, rec_rd_en[k], k <= 4);
      if (k <= 4) chk({tag, "_rd_addr"}, rec_rd_addr[k], k - 1);
      chk({tag, "_wr_en"}, rec_wr_en[k], k >= 3 && k <= 6);
      if (k >= 3 && k <= 6) begin
        chk({tag, "_wr_addr"}, rec_wr_addr[k], k - 3);
        chk({tag, "_wr_data"}, rec_wr_data[k], lit_out[k-3]);
      end
      chk({tag, "_done"}, rec_done[k], k == 7);
      chk({tag, "_busy"}, rec_busy[k], k <= 6);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t2_wa [1:10];
    int nd;
    bit fin;
    t2_wa = '{-1, -1, 0, 1, 1, 1, 2, 3, -1, -1};
    // threshold 0x80 replaces bytes above it with 0x55
    lit_out = '{8'h10, 8'h55, 8'h55, 8'h3C};
    mem_in  = '{8'h10, 8'hA0, 8'hFF, 8'h3C};
    cfg_threshold = 8'h80; cfg_value = 8'h55; cfg_select = 2'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_reset", {rd_en, wr_en, px_en, busy, done, rd_addr, wr_addr, px_threshold}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // nominal frame, no backpressure
    run_directed(9, 0, 0, 0, 0);
    check_nominal("t1");
    for (int i = 0; i < N; i++) chk("t1_mem_out", mem_out[i], lit_out[i]);

    // backpressure in cycles 4-5
    run_directed(10, 4, 5, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      chk("t2_wr_en", rec_wr_en[k], t2_wa[k] >= 0);
      if (t2_wa[k] >= 0) begin
        chk("t2_wr_addr", rec_wr_addr[k], t2_wa[k]);
        chk("t2_wr_data", rec_wr_data[k], lit_out[t2_wa[k]]);
      end
      chk("t2_rd_en", rec_rd_en[k], k <= 3 || k == 6);
      chk("t2_px_en", rec_px_en[k], k <= 8 && k != 4 && k != 5);
      chk("t2_done", rec_done[k], k == 9);
    end

    // start re-pulsed mid-frame with a new threshold
    run_directed(10, 0, 0, 0, 3);
    cfg_threshold = 8'h80;
    nd = 0;
    for (int k = 1; k <= 10; k++) nd += int'(rec_done[k]);
    for (int k = 3; k <= 6; k++) chk("t3_thr_held", rec_thr[k], 8'h80);
    chk("t3_one_done", nd, 1);

    // abort in cycle 4, then a clean frame
    run_directed(10, 0, 0, 4, 0);
    chk("t4_wr_en_c4", rec_wr_en[4], 1'b1);
    for (int k = 5; k <= 10; k++)
      chk("t4_after_abort", {rec_rd_en[k], rec_wr_en[k], rec_px_en[k], rec_busy[k], rec_done[k]}, 5'd0);
    run_directed(9, 0, 0, 0, 0);
    check_nominal("t4b");

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t5_start_wins", busy, 1'b1);
    fin = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      tick();
      if (!busy && !done) fin = 1;
    end
    chk("t5_frame_end", fin, 1'b1);

    // async reset in cycle 3
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {rd_en, wr_en, px_en, busy, done, rd_addr, wr_addr,
                           px_threshold, px_value, px_select}, 32'd0);
    tick();
    rst_n = 1'b1;
    run_directed(9, 0, 0, 0, 0);
    check_nominal("t6");

    // randomized frames: data, operands, backpressure, stray start/abort
    for (int f = 0; f < 40; f++) begin
      abort = ($urandom_range(0, 1) == 1);
      tick();
      abort = 1'b0;
      for (int i = 0; i < N; i++) mem_in[i] = 8'($urandom);
      cfg_threshold = 8'($urandom); cfg_value = 8'($urandom);
      cfg_select = 2'($urandom_range(0, 3));
      start = 1'b1;
      wr_ready = ($urandom_range(0, 3) != 0);
      tick();
      start = 1'b0;
      fin = 0;
      for (int c = 0; c < 60 && !fin; c++) begin
        wr_ready = ($urandom_range(0, 3) != 0);
        abort    = ($urandom_range(0, 39) == 0);
        start    = (busy || done) && ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) begin
          cfg_threshold = 8'($urandom); cfg_value = 8'($urandom);
          cfg_select = 2'($urandom_range(0, 3));
        end
        tick();
        if (!busy && !done) fin = 1;
      end
      start = 1'b0; abort = 1'b0;
      chk("rand_frame_end", fin, 1'b1);
    end
    wr_ready = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
